// File: rtl/ternary_mp_add_seq.sv
// Multi-precision balanced-ternary add/subtract sequencer.
// Streams WIDTH-trit operand words LS word first through one word-wide trit adder,
// carries the trit carry between words and returns registered sum words.
// Trit encoding (2 bits): 2'b00 = 0, 2'b01 = +1, 2'b10 = -1 (2'b11 reads as 0).
// Word buses pack trit i at bits [2*i+1:2*i].
module ternary_mp_add_seq #(
  parameter int unsigned WIDTH     = 27,
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 start_sub,
  input  logic [1:0]           start_cin,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_a,
  input  logic [2*WIDTH-1:0]   in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_sum,
  output logic                 out_last,
  output logic [1:0]           out_cout,
  output logic                 trunc_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count
);

  localparam logic [1:0] T_ZERO    = 2'b00;
  localparam logic [1:0] T_POS_ONE = 2'b01;
  localparam logic [1:0] T_NEG_ONE = 2'b10;

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state;
  logic [1:0]         carry;
  logic               sub;
  logic [2*WIDTH-1:0] b_eff;
  logic [2*WIDTH-1:0] cla_sum;
  logic [1:0]         cla_cout;
  logic               accept;
  logic               force_end;

  function automatic int trit_val(input logic [1:0] t);
    case (t)
      T_POS_ONE: return 1;
      T_NEG_ONE: return -1;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input int v);
    if (v > 0) return T_POS_ONE;
    if (v < 0) return T_NEG_ONE;
    return T_ZERO;
  endfunction

  // Handshake status decoded from state and the output register.
  always_comb begin
    start_ready = (state == StIdle);
    busy        = (state != StIdle);
    in_ready    = (state == StRun) && (!out_valid || out_ready);
    accept      = in_valid && in_ready;
    force_end   = (word_count == LastCount);
  end

  // Trit-wise negation of B for subtract: swapping the two code bits maps +1 <-> -1.
  always_comb begin
    b_eff = in_b;
    if (sub) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        b_eff[2*i +: 2] = {in_b[2*i], in_b[2*i+1]};
      end
    end
  end

  // Word adder: per-trit sum in -3..3 is folded back to one trit plus a carry trit.
  always_comb begin
    int         s;
    logic [1:0] c;
    s       = 0;
    c       = carry;
    cla_sum = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s = trit_val(in_a[2*i +: 2]) + trit_val(b_eff[2*i +: 2]) + trit_val(c);
      if (s > 1) begin
        s = s - 3;
        c = T_POS_ONE;
      end else if (s < -1) begin
        s = s + 3;
        c = T_NEG_ONE;
      end else begin
        c = T_ZERO;
      end
      cla_sum[2*i +: 2] = trit_enc(s);
    end
    cla_cout = c;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      carry      <= T_ZERO;
      sub        <= 1'b0;
      word_count <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_last   <= 1'b0;
      out_cout   <= T_ZERO;
      trunc_err  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start_valid) begin
            sub        <= start_sub;
            carry      <= start_cin;
            word_count <= '0;
            trunc_err  <= 1'b0;
            state      <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            out_sum    <= cla_sum;
            out_valid  <= 1'b1;
            carry      <= cla_cout;
            word_count <= word_count + CNT_W'(1);
            if (in_last || force_end) begin
              out_last <= 1'b1;
              out_cout <= cla_cout;
              state    <= StDrain;
              if (!in_last) trunc_err <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        StDrain: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_cout  <= T_ZERO;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_mp_add_seq.sv
// Scoreboard bench for ternary_mp_add_seq: the driver pushes word-level expected results
// computed with integer arithmetic; a monitor pops and compares on every output handshake.
module tb_ternary_mp_add_seq;

  localparam int W  = 27;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);
  localparam longint P    = 64'sd7625597484987;  // 3^27
  localparam longint HALF = (P - 1) / 2;
  localparam logic [1:0] TZ = 2'b00;
  localparam logic [1:0] TP = 2'b01;
  localparam logic [1:0] TN = 2'b10;

  logic            clk;
  logic            rst_n;
  logic            start_valid;
  logic            start_ready;
  logic            start_sub;
  logic [1:0]      start_cin;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  in_a;
  logic [2*W-1:0]  in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_sum;
  logic            out_last;
  logic [1:0]      out_cout;
  logic            trunc_err;
  logic            busy;
  logic [CW-1:0]   word_count;

  ternary_mp_add_seq #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_sub(start_sub), .start_cin(start_cin),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
    .out_cout(out_cout), .trunc_err(trunc_err), .busy(busy), .word_count(word_count)
  );

  typedef struct {
    logic [2*W-1:0] sum;
    logic           last;
    logic [1:0]     cout;
  } exp_t;

  exp_t   sb[$];
  int     total;
  int     bad;
  logic   m_sub;
  longint m_carry;
  int     m_count;
  logic   or_val;
  logic   or_mode;
  logic   or_rand;

  assign out_ready = or_mode ? or_rand : or_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    or_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 or_rand = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [2*W-1:0] enc(input longint v0);
    longint         v;
    longint         r;
    logic [2*W-1:0] w;
    v = v0;
    w = '0;
    for (int i = 0; i < W; i++) begin
      r = v % 3;
      if (r < 0) r = r + 3;
      if (r == 1) begin
        w[2*i +: 2] = TP;
        v = (v - 1) / 3;
      end else if (r == 2) begin
        w[2*i +: 2] = TN;
        v = (v + 1) / 3;
      end else begin
        v = v / 3;
      end
    end
    return w;
  endfunction

  function automatic logic [1:0] enc_t(input longint c);
    if (c == 1) return TP;
    if (c == -1) return TN;
    return TZ;
  endfunction

  function automatic longint rnd_word();
    longint unsigned r;
    r = {32'($urandom), 32'($urandom)};
    r = r % 64'd7625597484987;
    return $signed(r) - HALF;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got sum %h required no output", out_sum);
        end else begin
          e = sb.pop_front();
          chk("sb_sum", 64'(out_sum), 64'(e.sum));
          chk("sb_last", 64'(out_last), 64'(e.last));
          chk("sb_cout", 64'(out_cout), 64'(e.cout));
        end
      end
    end
  end

  task automatic start_op(input logic sub, input logic [1:0] cin);
    int n;
    n = 0;
    while (!start_ready && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("start_ready_wait", 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    start_sub   = sub;
    start_cin   = cin;
    @(posedge clk);
    #1 start_valid = 1'b0;
    m_sub   = sub;
    m_carry = (cin == TP) ? 1 : (cin == TN) ? -1 : 0;
    m_count = 0;
  endtask

  task automatic send_word(input longint a, input longint b, input logic last, input int bound,
                           output logic acc);
    longint t;
    longint c;
    logic   lw;
    in_valid = 1'b1;
    in_a     = enc(a);
    in_b     = enc(b);
    in_last  = last;
    acc      = 1'b0;
    for (int n = 0; n < bound && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (acc) begin
      t = a + (m_sub ? -b : b) + m_carry;
      c = 0;
      if (t > HALF) begin
        c = 1;
        t = t - P;
      end else if (t < -HALF) begin
        c = -1;
        t = t + P;
      end
      m_carry = c;
      m_count++;
      lw = last || (m_count == MW);
      sb.push_back('{sum: enc(t), last: lw, cout: lw ? enc_t(c) : TZ});
    end
  endtask

  task automatic send_ok(input longint a, input longint b, input logic last);
    logic acc;
    send_word(a, b, last, 300, acc);
    chk("word_accept", 64'(acc), 64'd1);
  endtask

  initial begin
    logic           acc;
    logic [2*W-1:0] held;
    int             nw;
    logic [1:0]     cin;
    int             n;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    start_sub = 1'b0;
    start_cin = TZ;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    or_val = 1'b1;
    or_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'(TZ));
    chk("rst_trunc_err", 64'(trunc_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word 13 + 14.
    start_op(1'b0, TZ);
    send_ok(13, 14, 1'b1);
    chk("single_latency", 64'(out_valid), 64'd1);
    chk("single_sum", 64'(out_sum), 64'(enc(27)));
    chk("single_wc", 64'(word_count), 64'd1);
    @(posedge clk);
    #1;
    chk("single_idle", 64'(busy), 64'd0);

    // Two-word carry chain.
    start_op(1'b0, TZ);
    send_ok(HALF, 1, 1'b0);
    chk("chain_w0_sum", 64'(out_sum), 64'(enc(-HALF)));
    chk("chain_w0_last", 64'(out_last), 64'd0);
    send_ok(0, 0, 1'b1);

    // Subtracts.
    start_op(1'b1, TZ);
    send_ok(100, 50, 1'b1);
    start_op(1'b1, TZ);
    send_ok(-1000, -2000, 1'b1);

    // Backpressure: consumer stalls three cycles after the first word.
    start_op(1'b0, TN);
    or_val = 1'b0;
    send_ok(HALF, HALF, 1'b0);
    held = out_sum;
    in_valid = 1'b1;
    in_a = enc(-HALF);
    in_b = enc(5);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(out_sum), 64'(held));
      @(posedge clk);
      #1;
    end
    or_val = 1'b1;
    send_ok(-HALF, 5, 1'b0);
    send_ok(7, 8, 1'b1);

    // Truncation at MW words without in_last.
    start_op(1'b0, TZ);
    for (int i = 0; i < MW; i++) send_ok(rnd_word(), rnd_word(), 1'b0);
    send_word(11, 12, 1'b0, 6, acc);
    chk("trunc_reject", 64'(acc), 64'd0);
    chk("trunc_err_set", 64'(trunc_err), 64'd1);
    chk("trunc_idle", 64'(busy), 64'd0);
    chk("trunc_wc_hold", 64'(word_count), 64'(MW));

    // Reset mid-operation, then a fresh op with cin = +1.
    start_op(1'b0, TZ);
    chk("trunc_err_clear", 64'(trunc_err), 64'd0);
    or_val = 1'b0;
    send_ok(5, 6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(out_sum), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_wc", 64'(word_count), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    or_val = 1'b1;
    @(posedge clk);
    #1;
    start_op(1'b0, TP);
    send_ok(1, 1, 1'b1);
    chk("post_rst_sum", 64'(out_sum), 64'(enc(3)));

    // Random operations with random consumer stalls.
    or_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin
      nw = $urandom_range(1, MW);
      case ($urandom_range(0, 2))
        0:       cin = TZ;
        1:       cin = TP;
        default: cin = TN;
      endcase
      start_op(1'($urandom_range(0, 1)), cin);
      for (int w = 0; w < nw; w++) send_ok(rnd_word(), rnd_word(), w == nw - 1);
    end

    or_mode = 1'b0;
    or_val = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_mp_add_seq.md
Name: ternary_mp_add_seq

Overview:
- Multi-precision sequencer around a single WIDTH-trit ternary_cla instance. Adds or subtracts balanced-ternary operands of up to MAX_WORDS words.
- Operands stream in least-significant word first. The block carries the trit carry between words and streams registered sum words out.
- It sits between the TPU accumulator/scalar-unit requesters and the shared CLA datapath, making wide (54/81/...-trit) arithmetic from one 27-trit adder.

Parameters:
- WIDTH, 27, trits per word; passed to the internal ternary_cla.
- MAX_WORDS, 8, maximum words per operation; must be >= 1.
- CNT_W, $clog2(MAX_WORDS+1), width of word_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to begin an operation.
- start_ready  out  1  high only in IDLE.
- start_sub  in  1  1 = compute A - B + cin, 0 = A + B + cin; latched at start.
- start_cin  in  trit_t  initial carry-in; latched at start.
- in_valid  in  1  operand word valid.
- in_ready  out  1  operand word accepted when in_valid && in_ready.
- in_a  in  trit_t[WIDTH]  operand A word.
- in_b  in  trit_t[WIDTH]  operand B word.
- in_last  in  1  marks the most-significant word.
- out_valid  out  1  sum word valid.
- out_ready  in  1  consumer accepts the sum word.
- out_sum  out  trit_t[WIDTH]  sum word.
- out_last  out  1  final word of the operation.
- out_cout  out  trit_t  final carry-out; meaningful only when out_last=1, otherwise T_ZERO.
- trunc_err  out  1  sticky flag: operation was cut at MAX_WORDS without in_last.
- busy  out  1  high whenever state != IDLE.
- word_count  out  CNT_W  number of words accepted in the current operation.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, carry register=T_ZERO, sub=0, word_count=0.
  - out_valid=0, out_sum=all T_ZERO, out_last=0, out_cout=T_ZERO, trunc_err=0, busy=0.
  - Reset asserted mid-operation abandons the operation; there is no partial output after release.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - start_ready=1, in_ready=0.
  - On start_valid: latch start_sub into sub, load carry<=start_cin, clear word_count, clear trunc_err, go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready (single output register with pass-through on simultaneous drain).
  - The CLA sees a=in_a, b=(sub ? negated in_b : in_b), cin=carry register.
  - Negation is trit-wise: T_POS_ONE<->T_NEG_ONE, T_ZERO unchanged. Subtract needs no +1 correction.
  - On accept:
    - out_sum<=CLA sum, out_valid<=1, carry<=CLA cout, word_count+=1.
    - If in_last=1 or word_count==MAX_WORDS-1: out_last<=1, out_cout<=CLA cout, go to DRAIN.
    - If termination is forced by the word count with in_last=0, also set trunc_err<=1.
- DRAIN:
  - in_ready=0.
  - When out_valid && out_ready: out_valid<=0, out_last<=0, out_cout<=T_ZERO, go to IDLE.
- Output handshake:
  - out_sum, out_last and out_cout stay stable while out_valid && !out_ready.
  - out_valid clears on a handshake unless a new word is accepted in the same cycle.
- Latency: one cycle from operand accept to out_valid. Sustained throughput is one word per cycle with out_ready=1.
- trunc_err holds until the next accepted start. word_count holds its final value in IDLE.
- start_valid outside IDLE is ignored. in_valid outside RUN is ignored.

Test Plan:
- Single word: start_sub=0, cin=T_ZERO, in_a=13, in_b=14, in_last=1 -> next cycle out_valid=1, out_sum=27, out_last=1, out_cout=T_ZERO, word_count=1; back to IDLE after out_ready.
- Two-word carry chain:
  - Word0: in_a=all T_POS_ONE, in_b=+1.
  - Word1: in_a=0, in_b=0, last.
  - Result: word0 out_sum=all T_NEG_ONE, out_last=0. Word1 out_sum=+1 (trit0=T_POS_ONE), out_cout=T_ZERO, out_last=1.
- Subtract: start_sub=1, cin=T_ZERO, in_a=100, in_b=50, last -> out_sum=50. Then in_a=-1000, in_b=-2000 -> out_sum=1000.
- Backpressure: 3-word add with out_ready=0 for 3 cycles after first output -> in_ready=0, out_sum held stable, no words lost. Resuming out_ready=1 yields all 3 words in order with correct carries.
- Truncation: MAX_WORDS=2, send 3 words without in_last -> 2nd output has out_last=1, trunc_err=1. The 3rd word is not accepted (in_ready=0) and the block returns to IDLE.
- Reset mid-op: assert rst_n=0 after 1 of 3 words -> outputs immediately at reset values. A new start then computes 1+1+cin T_POS_ONE=3 correctly with fresh carry.
